// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encoding, mode helpers and slave FSM states.
package spi_pkg;
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  function automatic logic cpol(spi_mode_t m);
    return m[1];
  endfunction
  function automatic logic cpha(spi_mode_t m);
    return m[0];
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer producing single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= {(STAGES+1){RST_VAL}};
    else s <= {s[STAGES-1:0], d};
  assign rise = s[STAGES-1] & ~s[STAGES];
  assign fall = ~s[STAGES-1] & s[STAGES];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target, all CPOL/CPHA modes, LSB-first full duplex.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_oe,
  input  logic [DATA_WIDTH-1:0] snd_data,
  input  logic                  load,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rcv_data,
  output logic                  done,
  output logic                  abort,
  output logic                  underrun
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t                  state;
  spi_mode_t               cur_mode;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_buf, tx_shift, rx_nxt;
  logic [DATA_WIDTH-2:0]   rx_shift;
  logic                    tx_full;
  logic [SYNC_STAGES-1:0]  mosi_r;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall, lead, trail, shift_en, sample_en;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(SS), .rise(ss_rise), .fall(ss_fall));
  always_ff @(posedge clk or negedge rst)
    if (!rst) mosi_r <= '0;
    else mosi_r <= {mosi_r[SYNC_STAGES-2:0], MOSI};
  always_comb begin
    lead      = cpol(cur_mode) ? sclk_fall : sclk_rise;
    trail     = cpol(cur_mode) ? sclk_rise : sclk_fall;
    // CPHA=1 presents bit 0 on the first leading edge, so no shift there
    shift_en  = cpha(cur_mode) ? (lead && bit_cnt != '0) : trail;
    sample_en = cpha(cur_mode) ? trail : lead;
    rx_nxt    = {mosi_r[SYNC_STAGES-1], rx_shift};
  end
  assign MISO  = MISO_oe & tx_shift[0];
  assign ready = ~tx_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cur_mode <= MODE0;
      bit_cnt  <= '0;
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rcv_data <= '0;
      done     <= 1'b0;
      abort    <= 1'b0;
      underrun <= 1'b0;
      MISO_oe  <= 1'b0;
    end else begin
      done     <= 1'b0;
      abort    <= 1'b0;
      underrun <= 1'b0;
      if (load && !tx_full) begin
        tx_buf  <= snd_data;
        tx_full <= 1'b1;
      end
      case (state)
        IDLE: if (ss_fall) begin
          state    <= ACTIVE;
          cur_mode <= spi_mode_t'(mode);
          bit_cnt  <= '0;
          MISO_oe  <= 1'b1;
          tx_full  <= 1'b0;
          tx_shift <= tx_full ? tx_buf : load ? snd_data : '0;
          underrun <= !tx_full && !load;
        end
        ACTIVE: if (ss_rise) begin
          state   <= IDLE;
          abort   <= 1'b1;
          MISO_oe <= 1'b0;
        end else begin
          if (shift_en) tx_shift <= tx_shift >> 1;
          if (sample_en) begin
            rx_shift <= rx_nxt[DATA_WIDTH-1:1];
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST) begin
              rcv_data <= rx_nxt;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: if (ss_rise) begin
          state   <= IDLE;
          MISO_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
